// File: rtl/bcd_countdown_timer.sv
// Countdown core for the egg-timer family: DIGITS-wide BCD count with load clamping,
// prescaled decrement, pause/resume and a timed blinking alarm at zero.
module bcd_countdown_timer #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned MMSS        = 1,
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  LOAD,
    input  logic                  START_STOP,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   COUNT,
    output logic [2:0]            STATE,
    output logic                  TICK,
    output logic                  DONE,
    output logic                  ALARM,
    output logic                  BLINK
);
    localparam int unsigned CW = 4 * DIGITS;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned AW = $clog2(ALARM_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOADED  = 3'd1,
        S_RUNNING = 3'd2,
        S_PAUSED  = 3'd3,
        S_ALARM   = 3'd4
    } state_t;

    state_t          state;
    logic            load_q;
    logic            ss_q;
    logic [PW-1:0]   presc;
    logic [AW-1:0]   acnt;
    logic            load_ev;
    logic            ss_ev;
    logic            tick_hit;
    logic            count_zero;
    logic            dec_zero;
    logic [CW-1:0]   clamped;
    logic [CW-1:0]   dec;

    assign STATE = state;

    // Key press events and prescaler wrap
    always_comb begin : events
        load_ev  = LOAD & ~load_q;
        ss_ev    = START_STOP & ~ss_q;
        tick_hit = (presc == PRESC_MAX) && (state == S_RUNNING || state == S_ALARM);
    end

    // Saturate out-of-range digits of the switch value
    always_comb begin : load_clamp
        logic [3:0] d;
        clamped = '0;
        d       = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = LOAD_VAL[4*i +: 4];
            if (d > 4'd9) d = 4'd9;
            if (MMSS != 0 && i == 1 && d > 4'd5) d = 4'd5;
            clamped[4*i +: 4] = d;
        end
    end

    // BCD decrement with ripple borrow; seconds-tens wraps to 5 in MM:SS mode
    always_comb begin : bcd_dec
        logic [3:0] d;
        logic       borrow;
        dec    = '0;
        d      = '0;
        borrow = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = COUNT[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    d = (MMSS != 0 && i == 1) ? 4'd5 : 4'd9;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            dec[4*i +: 4] = d;
        end
        count_zero = (COUNT == '0);
        dec_zero   = (dec == '0);
    end

    always_ff @(posedge CLK) begin : fsm
        if (RESET) begin
            state  <= S_IDLE;
            COUNT  <= '0;
            presc  <= '0;
            acnt   <= '0;
            TICK   <= 1'b0;
            DONE   <= 1'b0;
            ALARM  <= 1'b0;
            BLINK  <= 1'b0;
            load_q <= 1'b1;
            ss_q   <= 1'b1;
        end else begin
            load_q <= LOAD;
            ss_q   <= START_STOP;
            TICK   <= 1'b0;
            DONE   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_ev) begin
                        state <= S_LOADED;
                        COUNT <= clamped;
                        presc <= '0;
                    end
                end
                S_LOADED: begin
                    if (load_ev) begin
                        COUNT <= clamped;
                    end else if (ss_ev && !count_zero) begin
                        state <= S_RUNNING;
                        presc <= '0;
                    end
                end
                S_RUNNING: begin
                    if (load_ev) begin
                        state <= S_LOADED;
                        COUNT <= clamped;
                        presc <= '0;
                    end else begin
                        presc <= tick_hit ? '0 : presc + PW'(1);
                        if (tick_hit) begin
                            TICK  <= 1'b1;
                            COUNT <= dec;
                            if (dec_zero) begin
                                state <= S_ALARM;
                                DONE  <= 1'b1;
                                ALARM <= 1'b1;
                                BLINK <= 1'b1;
                                acnt  <= '0;
                            end else if (ss_ev) begin
                                state <= S_PAUSED;
                            end
                        end else if (ss_ev) begin
                            state <= S_PAUSED;
                        end
                    end
                end
                S_PAUSED: begin
                    if (load_ev) begin
                        state <= S_LOADED;
                        COUNT <= clamped;
                        presc <= '0;
                    end else if (ss_ev) begin
                        state <= S_RUNNING;
                    end
                end
                S_ALARM: begin
                    if (load_ev || ss_ev) begin
                        // LOAD outranks acknowledge
                        state <= load_ev ? S_LOADED : S_IDLE;
                        if (load_ev) COUNT <= clamped;
                        presc <= '0;
                        acnt  <= '0;
                        ALARM <= 1'b0;
                        BLINK <= 1'b0;
                    end else begin
                        presc <= tick_hit ? '0 : presc + PW'(1);
                        if (tick_hit) begin
                            TICK <= 1'b1;
                            if (acnt == ALARM_LAST) begin
                                state <= S_IDLE;
                                acnt  <= '0;
                                ALARM <= 1'b0;
                                BLINK <= 1'b0;
                            end else begin
                                acnt  <= acnt + AW'(1);
                                BLINK <= ~BLINK;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: MM:SS and decimal instances share stimulus.
module tb_bcd_countdown_timer;
    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        ss;
    logic [15:0] load_val;
    logic [15:0] count, count_d;
    logic [2:0]  state, state_d;
    logic        tick, done, alarm, blink;
    logic        tick_d, done_d, alarm_d, blink_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.DIGITS(4), .TICK_DIV(4), .MMSS(1), .ALARM_TICKS(10)) dut (
        .CLK(clk), .RESET(reset), .LOAD(load), .START_STOP(ss), .LOAD_VAL(load_val),
        .COUNT(count), .STATE(state), .TICK(tick), .DONE(done), .ALARM(alarm), .BLINK(blink)
    );

    bcd_countdown_timer #(.DIGITS(4), .TICK_DIV(4), .MMSS(0), .ALARM_TICKS(10)) dut_dec (
        .CLK(clk), .RESET(reset), .LOAD(load), .START_STOP(ss), .LOAD_VAL(load_val),
        .COUNT(count_d), .STATE(state_d), .TICK(tick_d), .DONE(done_d), .ALARM(alarm_d),
        .BLINK(blink_d)
    );

    typedef enum logic [1:0] {OP_WAIT, OP_LOAD, OP_SS, OP_BOTH} op_t;

    typedef struct {
        op_t         op;
        logic [15:0] val;
        int          cyc;
        logic [2:0]  st;
        logic [15:0] cnt;
        logic [3:0]  fl;   // {TICK, DONE, ALARM, BLINK}
        logic [15:0] dcnt;
    } vec_t;

    localparam int NV = 36;
    vec_t vecs[NV];

    function automatic vec_t mk(op_t op, logic [15:0] val, int cyc, logic [2:0] st,
                                logic [15:0] cnt, logic [3:0] fl, logic [15:0] dcnt);
        vec_t v;
        v.op = op; v.val = val; v.cyc = cyc; v.st = st; v.cnt = cnt; v.fl = fl; v.dcnt = dcnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [15:0] cnt,
                             input logic [3:0] fl);
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " count"}, 32'(count), 32'(cnt));
        check({tag, " flags"}, 32'({tick, done, alarm, blink}), 32'(fl));
    endtask

    // One key action edge, keys released, then remaining cycles before sampling
    task automatic do_op(input vec_t v);
        if (v.op == OP_LOAD || v.op == OP_BOTH) load_val = v.val;
        load = (v.op == OP_LOAD || v.op == OP_BOTH);
        ss   = (v.op == OP_SS   || v.op == OP_BOTH);
        @(posedge clk);
        #1;
        load = 1'b0;
        ss   = 1'b0;
        step(v.cyc - 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(OP_LOAD, 16'h0F7F, 2,  3'd1, 16'h0959, 4'h0, 16'h0979);
        vecs[1]  = mk(OP_LOAD, 16'h0100, 1,  3'd1, 16'h0100, 4'h0, 16'h0100);
        vecs[2]  = mk(OP_SS,   16'h0000, 4,  3'd2, 16'h0100, 4'h0, 16'h0100);
        vecs[3]  = mk(OP_WAIT, 16'h0000, 1,  3'd2, 16'h0059, 4'h8, 16'h0099);
        vecs[4]  = mk(OP_WAIT, 16'h0000, 4,  3'd2, 16'h0058, 4'h8, 16'h0098);
        vecs[5]  = mk(OP_WAIT, 16'h0000, 3,  3'd2, 16'h0058, 4'h0, 16'h0098);
        vecs[6]  = mk(OP_LOAD, 16'h0003, 1,  3'd1, 16'h0003, 4'h0, 16'h0003);
        vecs[7]  = mk(OP_SS,   16'h0000, 2,  3'd2, 16'h0003, 4'h0, 16'h0003);
        vecs[8]  = mk(OP_SS,   16'h0000, 1,  3'd3, 16'h0003, 4'h0, 16'h0003);
        vecs[9]  = mk(OP_WAIT, 16'h0000, 20, 3'd3, 16'h0003, 4'h0, 16'h0003);
        vecs[10] = mk(OP_SS,   16'h0000, 1,  3'd2, 16'h0003, 4'h0, 16'h0003);
        vecs[11] = mk(OP_WAIT, 16'h0000, 1,  3'd2, 16'h0003, 4'h0, 16'h0003);
        vecs[12] = mk(OP_WAIT, 16'h0000, 1,  3'd2, 16'h0002, 4'h8, 16'h0002);
        vecs[13] = mk(OP_LOAD, 16'h0001, 1,  3'd1, 16'h0001, 4'h0, 16'h0001);
        vecs[14] = mk(OP_SS,   16'h0000, 4,  3'd2, 16'h0001, 4'h0, 16'h0001);
        vecs[15] = mk(OP_WAIT, 16'h0000, 1,  3'd4, 16'h0000, 4'hF, 16'h0000);
        vecs[16] = mk(OP_WAIT, 16'h0000, 1,  3'd4, 16'h0000, 4'h3, 16'h0000);
        vecs[17] = mk(OP_WAIT, 16'h0000, 3,  3'd4, 16'h0000, 4'hA, 16'h0000);
        vecs[18] = mk(OP_WAIT, 16'h0000, 4,  3'd4, 16'h0000, 4'hB, 16'h0000);
        vecs[19] = mk(OP_WAIT, 16'h0000, 31, 3'd4, 16'h0000, 4'h2, 16'h0000);
        vecs[20] = mk(OP_WAIT, 16'h0000, 1,  3'd0, 16'h0000, 4'h8, 16'h0000);
        vecs[21] = mk(OP_WAIT, 16'h0000, 1,  3'd0, 16'h0000, 4'h0, 16'h0000);
        vecs[22] = mk(OP_SS,   16'h0000, 2,  3'd0, 16'h0000, 4'h0, 16'h0000);
        vecs[23] = mk(OP_LOAD, 16'h0000, 2,  3'd1, 16'h0000, 4'h0, 16'h0000);
        vecs[24] = mk(OP_SS,   16'h0000, 2,  3'd1, 16'h0000, 4'h0, 16'h0000);
        vecs[25] = mk(OP_LOAD, 16'h0042, 2,  3'd1, 16'h0042, 4'h0, 16'h0042);
        vecs[26] = mk(OP_SS,   16'h0000, 2,  3'd2, 16'h0042, 4'h0, 16'h0042);
        vecs[27] = mk(OP_BOTH, 16'h0017, 2,  3'd1, 16'h0017, 4'h0, 16'h0017);
        vecs[28] = mk(OP_LOAD, 16'h0001, 2,  3'd1, 16'h0001, 4'h0, 16'h0001);
        vecs[29] = mk(OP_SS,   16'h0000, 5,  3'd4, 16'h0000, 4'hF, 16'h0000);
        vecs[30] = mk(OP_SS,   16'h0000, 2,  3'd0, 16'h0000, 4'h0, 16'h0000);
        vecs[31] = mk(OP_LOAD, 16'h0001, 2,  3'd1, 16'h0001, 4'h0, 16'h0001);
        vecs[32] = mk(OP_SS,   16'h0000, 5,  3'd4, 16'h0000, 4'hF, 16'h0000);
        vecs[33] = mk(OP_LOAD, 16'h0230, 2,  3'd1, 16'h0230, 4'h0, 16'h0230);
        vecs[34] = mk(OP_LOAD, 16'h1000, 2,  3'd1, 16'h1000, 4'h0, 16'h1000);
        vecs[35] = mk(OP_SS,   16'h0000, 5,  3'd2, 16'h0959, 4'h8, 16'h0999);

        reset    = 1'b1;
        load     = 1'b0;
        ss       = 1'b0;
        load_val = 16'h0000;
        step(3);
        check_all("reset", 3'd0, 16'h0000, 4'h0);
        check("reset dec count", 32'(count_d), 32'h0);
        reset = 1'b0;
        step(1);
        check_all("post-reset", 3'd0, 16'h0000, 4'h0);

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i]);
            check_all($sformatf("v%0d", i), vecs[i].st, vecs[i].cnt, vecs[i].fl);
            check($sformatf("v%0d dec count", i), 32'(count_d), 32'(vecs[i].dcnt));
        end

        // Key held through reset release must not register as a press
        load_val = 16'h0055;
        load     = 1'b1;
        reset    = 1'b1;
        step(2);
        reset = 1'b0;
        step(3);
        check_all("held key", 3'd0, 16'h0000, 4'h0);
        load = 1'b0;
        step(1);
        load = 1'b1;
        step(1);
        load = 1'b0;
        check_all("press after release", 3'd1, 16'h0055, 4'h0);

        // Reset while running discards the count
        load_val = 16'h0042;
        step(1);
        load = 1'b1;
        step(1);
        load = 1'b0;
        ss   = 1'b1;
        step(1);
        ss = 1'b0;
        step(2);
        check_all("run 0042", 3'd2, 16'h0042, 4'h0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_all("reset mid-run", 3'd0, 16'h0000, 4'h0);
        check("reset mid-run dec state", 32'(state_d), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
